// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: state encoding, source
// indices, mcause values and vector-table offsets.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Source index order doubles as priority order: lower index wins.
    localparam int unsigned      IDX_W        = 5;
    localparam logic [IDX_W-1:0] IDX_NMI      = 5'd0;
    localparam logic [IDX_W-1:0] IDX_TIMER    = 5'd1;
    localparam logic [IDX_W-1:0] IDX_EXT_BASE = 5'd2;

    localparam logic [31:0] CAUSE_NMI      = 32'h8000_0000;
    localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT_BASE = 32'h8000_0010;

    localparam logic [31:0] VIDX_TIMER    = 32'd7;
    localparam logic [31:0] VIDX_EXT_BASE = 32'd16;

    function automatic logic [31:0] ext_offset(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] k;
        k = idx - IDX_EXT_BASE;
        return {{(32-IDX_W){1'b0}}, k};
    endfunction

    function automatic logic [31:0] cause_of(input logic [IDX_W-1:0] idx);
        if (idx == IDX_NMI)
            return CAUSE_NMI;
        else if (idx == IDX_TIMER)
            return CAUSE_TIMER;
        else
            return CAUSE_EXT_BASE + ext_offset(idx);
    endfunction

    function automatic logic [31:0] vector_of(input logic [IDX_W-1:0] idx,
                                              input logic [31:0]      vec_base,
                                              input logic [31:0]      nmi_vec);
        if (idx == IDX_NMI)
            return nmi_vec;
        else if (idx == IDX_TIMER)
            return vec_base + (VIDX_TIMER << 2);
        else
            return vec_base + ((VIDX_EXT_BASE + ext_offset(idx)) << 2);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder over the eligible source vector
// {ext, timer, nmi}; bit 0 has the highest priority.
module irq_prio_enc
    import irq_controller_pkg::*;
#(
    parameter int unsigned NUM_SRC = 6
) (
    input  logic [NUM_SRC-1:0] elig,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt latch/arbiter with req/ack handshake to the core trap logic.
// Optional IRQ_STATS_EN adds an accepted-interrupt counter port.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned NUM_EXT    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] NMI_VEC    = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tmrF,
    input  logic               nmi,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic [NUM_EXT-1:0] ext_mask,
    input  logic               ie,
    input  logic               irq_ack,
    input  logic               mret,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic [31:0]        irq_vector,
    output logic               in_service
`ifdef IRQ_STATS_EN
    ,
    output logic [31:0]        irq_count
`endif
);

    localparam int unsigned NUM_SRC = NUM_EXT + 2;

    state_t             state, state_nxt;
    logic               timer_pend, nmi_pend, nmi_q;
    logic [IDX_W-1:0]   win, win_nxt;
    logic [NUM_SRC-1:0] elig;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;
    logic               req_nxt, svc_nxt;
    logic [31:0]        cause_nxt, vector_nxt;
    logic               clr_timer, clr_nmi, win_live, accept;

    assign elig = {ext_irq & ext_mask & {NUM_EXT{ie}}, timer_pend & ie, nmi_pend};

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .elig  (elig),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_nxt  = state;
        req_nxt    = irq_req;
        svc_nxt    = in_service;
        cause_nxt  = irq_cause;
        vector_nxt = irq_vector;
        win_nxt    = win;
        clr_timer  = 1'b0;
        clr_nmi    = 1'b0;
        accept     = 1'b0;
        win_live   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IDX_W'(i) == win)
                win_live = elig[i];
        end

        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nxt  = REQ;
                    req_nxt    = 1'b1;
                    win_nxt    = enc_idx;
                    cause_nxt  = cause_of(enc_idx);
                    vector_nxt = vector_of(enc_idx, VEC_BASE, NMI_VEC);
                end
            end
            REQ: begin
                // An ack in the same cycle as a withdraw condition is honoured.
                if (irq_ack) begin
                    accept    = 1'b1;
                    clr_timer = (win == IDX_TIMER);
                    clr_nmi   = (win == IDX_NMI);
                    req_nxt   = 1'b0;
                    svc_nxt   = 1'b1;
                    state_nxt = SERVICE;
                end else if (win != IDX_NMI && !win_live) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (mret) begin
                    svc_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                svc_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer_pend <= 1'b0;
            nmi_pend   <= 1'b0;
            nmi_q      <= 1'b0;
            win        <= '0;
            irq_req    <= 1'b0;
            irq_cause  <= '0;
            irq_vector <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            win        <= win_nxt;
            irq_req    <= req_nxt;
            irq_cause  <= cause_nxt;
            irq_vector <= vector_nxt;
            in_service <= svc_nxt;
            // New events take precedence over a same-cycle clear.
            timer_pend <= tmrF | (timer_pend & ~clr_timer);
            nmi_pend   <= (nmi & ~nmi_q) | (nmi_pend & ~clr_nmi);
            nmi_q      <= nmi;
        end
    end

`ifdef IRQ_STATS_EN
    logic [31:0] nmi_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_count <= '0;
            nmi_count <= '0;
        end else if (accept) begin
            irq_count <= irq_count + 32'd1;
            if (win == IDX_NMI)
                nmi_count <= nmi_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a cycle-level
// behavioural model of pending events and the req/ack/mret handshake.
module tb_irq_controller;

    localparam int unsigned NE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tmrF = 1'b0;
    logic          nmi = 1'b0;
    logic          ie = 1'b0;
    logic          irq_ack = 1'b0;
    logic          mret = 1'b0;
    logic [NE-1:0] ext_irq = '0;
    logic [NE-1:0] ext_mask = '0;
    logic          irq_req, in_service;
    logic [31:0]   irq_cause, irq_vector;
`ifdef IRQ_STATS_EN
    logic [31:0]   irq_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_pt, m_pn, m_nq, m_req, m_svc;
    int          m_src;
    logic [31:0] m_cause, m_vec, m_cnt;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_EXT  (NE),
        .VEC_BASE (32'h0000_0100),
        .NMI_VEC  (32'h0000_0080)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tmrF       (tmrF),
        .nmi        (nmi),
        .ext_irq    (ext_irq),
        .ext_mask   (ext_mask),
        .ie         (ie),
        .irq_ack    (irq_ack),
        .mret       (mret),
        .irq_req    (irq_req),
        .irq_cause  (irq_cause),
        .irq_vector (irq_vector),
        .in_service (in_service)
`ifdef IRQ_STATS_EN
        ,
        .irq_count  (irq_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pt = 0; m_pn = 0; m_nq = 0; m_req = 0; m_svc = 0;
        m_src = -1; m_cause = '0; m_vec = '0; m_cnt = '0;
    endtask

    // Source numbering: 0 = NMI, 1 = timer, 2+k = external line k.
    function automatic bit live(input int s);
        if (s == 0) return m_pn;
        if (s == 1) return ie && m_pt;
        return ie && ext_irq[s-2] && ext_mask[s-2];
    endfunction

    function automatic int pick();
        for (int s = 0; s < int'(NE) + 2; s++)
            if (live(s)) return s;
        return -1;
    endfunction

    task automatic model_next();
        bit clr_t = 0;
        bit clr_n = 0;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_req) begin
            if (irq_ack) begin
                clr_t = (m_src == 1);
                clr_n = (m_src == 0);
                m_req = 0;
                m_svc = 1;
                m_cnt = m_cnt + 32'd1;
            end else if (m_src != 0 && !live(m_src)) begin
                m_req = 0;
            end
        end else if (m_svc) begin
            if (mret) m_svc = 0;
        end else begin
            w = pick();
            if (w >= 0) begin
                m_req = 1;
                m_src = w;
                if (w == 0) begin
                    m_cause = 32'h8000_0000;
                    m_vec   = 32'h0000_0080;
                end else if (w == 1) begin
                    m_cause = 32'h8000_0007;
                    m_vec   = 32'h0000_0100 + 32'd28;
                end else begin
                    m_cause = 32'h8000_0010 + (w - 2);
                    m_vec   = 32'h0000_0100 + 4 * (16 + w - 2);
                end
            end
        end
        m_pt = tmrF | (m_pt & !clr_t);
        m_pn = (nmi & !m_nq) | (m_pn & !clr_n);
        m_nq = nmi;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"}, 32'(irq_req), 32'(m_req));
        chk({tag, ".svc"}, 32'(in_service), 32'(m_svc));
        if (m_req) begin
            chk({tag, ".cause"}, irq_cause, m_cause);
            chk({tag, ".vector"}, irq_vector, m_vec);
        end
`ifdef IRQ_STATS_EN
        chk({tag, ".count"}, irq_count, m_cnt);
`endif
    endtask

    task automatic step(input string tag);
        model_next();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".req"}, 32'(irq_req), 32'd0);
        chk({tag, ".svc"}, 32'(in_service), 32'd0);
        chk({tag, ".cause"}, irq_cause, 32'd0);
        chk({tag, ".vector"}, irq_vector, 32'd0);
`ifdef IRQ_STATS_EN
        chk({tag, ".count"}, irq_count, 32'd0);
`endif
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_zero("reset");
        model_reset();
        step("rst_hold");
        rst = 1'b0;
        step("idle0");
        step("idle1");

        // Timer request, ack, mret
        ie = 1'b1;
        tmrF = 1'b1; step("tmr_pulse");
        tmrF = 1'b0; step("tmr_req");
        chk("tmr_req_lvl", 32'(irq_req), 32'd1);
        chk("tmr_cause", irq_cause, 32'h8000_0007);
        chk("tmr_vector", irq_vector, 32'h0000_011C);
        step("tmr_hold");
        irq_ack = 1'b1; step("tmr_ack");
        irq_ack = 1'b0;
        chk("tmr_ack_req", 32'(irq_req), 32'd0);
        chk("tmr_ack_svc", 32'(in_service), 32'd1);
        step("tmr_svc");
        mret = 1'b1; step("tmr_mret");
        mret = 1'b0;
        chk("tmr_mret_svc", 32'(in_service), 32'd0);
        step("tmr_idle");

        // NMI with ie=0 beats a pending ext[0]; ext[0] waits for ie and mret
        ie = 1'b0; ext_mask = 4'b1111; ext_irq = 4'b0001; nmi = 1'b1;
        step("nmi_edge");
        step("nmi_req");
        chk("nmi_cause", irq_cause, 32'h8000_0000);
        chk("nmi_vector", irq_vector, 32'h0000_0080);
        irq_ack = 1'b1; step("nmi_ack");
        irq_ack = 1'b0;
        step("nmi_svc0");
        step("nmi_svc1");
        ie = 1'b1; step("nmi_svc_ie");
        chk("nmi_no_nest", 32'(irq_req), 32'd0);
        mret = 1'b1; step("nmi_mret");
        mret = 1'b0; step("ext0_req");
        chk("ext0_cause", irq_cause, 32'h8000_0010);
        chk("ext0_vector", irq_vector, 32'h0000_0140);
        irq_ack = 1'b1; step("ext0_ack");
        irq_ack = 1'b0; ext_irq = '0; nmi = 1'b0;
        mret = 1'b1; step("ext0_mret");
        mret = 1'b0; step("idle2");

        // Timer and ext[2] arrive together during service: timer first
        tmrF = 1'b1; step("t2_pulse");
        tmrF = 1'b0; step("t2_req");
        irq_ack = 1'b1; step("t2_ack");
        irq_ack = 1'b0; tmrF = 1'b1; ext_irq = 4'b0100; step("both_arrive");
        tmrF = 1'b0; step("both_wait");
        mret = 1'b1; step("both_mret");
        mret = 1'b0; step("both_req");
        chk("prio_timer", irq_cause, 32'h8000_0007);
        irq_ack = 1'b1; step("prio_ack");
        irq_ack = 1'b0; mret = 1'b1; step("prio_mret");
        mret = 1'b0; step("ext2_req");
        chk("ext2_cause", irq_cause, 32'h8000_0012);
        irq_ack = 1'b1; step("ext2_ack");
        irq_ack = 1'b0; ext_irq = '0; mret = 1'b1; step("ext2_mret");
        mret = 1'b0; step("idle3");

        // Withdraw when ie drops before ack
        ext_irq = 4'b0010; step("ext1_req");
        chk("ext1_cause", irq_cause, 32'h8000_0011);
        ie = 1'b0; step("ext1_withdraw");
        chk("withdraw_req", 32'(irq_req), 32'd0);
        chk("withdraw_svc", 32'(in_service), 32'd0);
        ext_irq = '0; ie = 1'b1; step("idle4");

        // tmrF coinciding with the timer ack leaves the timer pending
        tmrF = 1'b1; step("co_pulse");
        tmrF = 1'b0; step("co_req");
        irq_ack = 1'b1; tmrF = 1'b1; step("co_ack");
        irq_ack = 1'b0; tmrF = 1'b0; step("co_svc");
        mret = 1'b1; step("co_mret");
        mret = 1'b0; step("co_req2");
        chk("co_second_req", 32'(irq_req), 32'd1);
        chk("co_second_cause", irq_cause, 32'h8000_0007);

        // Asynchronous reset while in REQ
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        step("rst_hold2");
        rst = 1'b0;
        step("after_rst");

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tmrF = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) nmi = ~nmi;
            if ($urandom_range(0, 7) == 0) ext_irq = NE'($urandom);
            if ($urandom_range(0, 31) == 0) ext_mask = NE'($urandom);
            ie = ($urandom_range(0, 9) != 0);
            irq_ack = ($urandom_range(0, 2) == 0);
            mret = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt arbiter and latch between the timer/NMI sources and the RV32IC core's trap-entry logic.
- Consumes the one-cycle `tmrF` pulse from the NMI/timer generator, a non-maskable `nmi` line and NUM_EXT external request lines.
- Latches pending events, selects one by fixed priority, and presents it to the core with a req/ack handshake carrying mcause and vector.
- Tracks the in-service state until the core executes MRET.

Parameters:
- NUM_EXT, 4, number of external interrupt lines (1..16)
- VEC_BASE, 32'h0000_0100, base of the vectored trap table for maskable sources
- NMI_VEC, 32'h0000_0080, fixed NMI handler address

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- tmrF  in  1  one-cycle timer tick pulse
- nmi  in  1  non-maskable request; rising edge detected
- ext_irq  in  NUM_EXT  level-sensitive external requests
- ext_mask  in  NUM_EXT  per-line enable (1 = enabled)
- ie  in  1  global maskable-interrupt enable (mstatus.MIE)
- irq_ack  in  1  core accepts the current request
- mret  in  1  one-cycle pulse, core executed MRET
- irq_req  out  1  request to core
- irq_cause  out  32  mcause value of the presented request
- irq_vector  out  32  handler address of the presented request
- in_service  out  1  handler active

Behaviour:
- Reset (async, rst=1): state IDLE, timer_pend=0, nmi_pend=0, nmi_q=0, irq_req=0, irq_cause=0, irq_vector=0, in_service=0.
- Pending capture, registered, visible the cycle after the event:
  - tmrF=1 sets timer_pend.
  - nmi=1 with nmi_q=0 sets nmi_pend; nmi_q <= nmi every cycle.
  - ext_irq is not latched; an external line is eligible while ext_irq[k] & ext_mask[k].
- Eligibility:
  - NMI is eligible whenever nmi_pend=1, regardless of ie.
  - Timer and external lines are eligible only when ie=1.
- Priority: NMI > timer > ext[0] > ext[1] > ... > ext[NUM_EXT-1].
- Encoding:
  - NMI: cause 32'h8000_0000, vector NMI_VEC.
  - Timer: cause 32'h8000_0007, vector VEC_BASE+4*7.
  - ext[k]: cause 32'h8000_0010+k, vector VEC_BASE+4*(16+k).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if any source is eligible, register the winner's cause/vector, set irq_req=1, go REQ. Latency is 1 cycle from pending set to irq_req.
  - REQ: irq_req, irq_cause and irq_vector are held stable.
    - irq_ack=1: clear the winner's pending bit (timer_pend or nmi_pend; external lines have none), irq_req=0, in_service=1, go SERVICE.
    - Winner is maskable and ie drops or its source deasserts before ack: withdraw, irq_req=0, go IDLE. NMI requests are never withdrawn.
  - SERVICE: no new request is presented; pending bits keep accumulating. mret=1: in_service=0, go IDLE. Re-arbitration happens the following cycle.
- Boundary conditions:
  - A tmrF pulse in the same cycle its pending bit is cleared by ack leaves timer_pend=1 (set wins).
  - Repeated tmrF pulses while pending collapse into one.
  - irq_ack outside REQ and mret outside SERVICE are ignored.
  - There is no nesting; an NMI arriving during SERVICE waits for mret.
  - Reset asserted mid-handshake aborts immediately to the reset values.

Optional Feature:
- Macro IRQ_STATS_EN.
- Defined: adds output port irq_count (32 bits), reset 0, incremented on each accepted ack (REQ & irq_ack). It wraps from 32'hFFFF_FFFF to 0. A separate 32-bit counter, nmi_count, counts NMI acceptances only.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - cause constants CAUSE_NMI, CAUSE_TIMER, CAUSE_EXT_BASE
  - vector index constants
  - state encoding IDLE/REQ/SERVICE
- One natural sub-module, irq_prio_enc: combinational fixed-priority encoder. Inputs are the eligible vector {nmi, timer, ext}; outputs are a valid flag plus the winner index, from which cause/vector are derived.

Test Plan:
- Reset, then ie=1 and a tmrF pulse at cycle 5: irq_req=1 at cycle 7 with cause 32'h8000_0007 and vector 32'h0000_011C. Ack at cycle 9: irq_req=0 and in_service=1 at cycle 10. mret at cycle 12: in_service=0 at cycle 13.
- ie=0, nmi rising and ext_irq=4'b0001 with mask 4'b1111: NMI presented with cause 32'h8000_0000 and vector 32'h0000_0080. After ack, the ext line stays unserviced until ie=1 and mret, then is presented with cause 32'h8000_0010 and vector 32'h0000_0140.
- tmrF and ext_irq[2] in the same cycle with ie=1: timer wins. After mret, ext[2] is presented with cause 32'h8000_0012.
- In REQ for ext[1], deassert ie before ack: irq_req drops the next cycle, state IDLE, no in_service.
- tmrF pulse coinciding with an ack of the timer request: timer_pend remains 1, and a second timer request appears after mret.
- Assert rst asynchronously mid-REQ: all outputs become 0 without waiting for a clock edge. With IRQ_STATS_EN defined, irq_count returns to 0.
